// File: rtl/expr_eval_sequencer.sv
// expr_eval_sequencer: shunting-yard expression evaluator. Tokens from the
// lexer are scheduled over an operand stack and an operator stack, and one
// shared W-bit ALU performs a single reduction per cycle. The result (or an
// error code) is held until the downstream sink accepts it.
module expr_eval_sequencer #(
  parameter int W     = 32,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tok_valid,
  output logic         tok_ready,
  input  logic [2:0]   tok_kind,
  input  logic [3:0]   tok_op,
  input  logic [W-1:0] tok_val,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_data,
  output logic [2:0]   res_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [2:0] K_NUM    = 3'd0;
  localparam logic [2:0] K_OP     = 3'd1;
  localparam logic [2:0] K_LPAREN = 3'd2;
  localparam logic [2:0] K_RPAREN = 3'd3;
  localparam logic [2:0] K_END    = 3'd4;

  // Highest legal operator code; 4'hF never arrives legally, so it doubles
  // as the LPAREN marker on the operator stack.
  localparam logic [3:0] OP_MAX    = 4'd9;
  localparam logic [3:0] OP_LPAREN = 4'hF;

  localparam logic [2:0] ERR_OVF = 3'b001;
  localparam logic [2:0] ERR_DIV = 3'b010;
  localparam logic [2:0] ERR_SYN = 3'b100;

  localparam logic signed [W-1:0] S_MIN = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {S_ACCEPT, S_REDUCE, S_DRAIN, S_DONE} state_t;
  // Why we are reducing: a pending operator, a closing paren, or END.
  typedef enum logic [1:0] {M_OP, M_RPAREN, M_END} mode_t;

  function automatic logic [2:0] prec(input logic [3:0] op);
    case (op)
      4'd2, 4'd3:             prec = 3'd4;
      4'd0, 4'd1:             prec = 3'd3;
      4'd6, 4'd7, 4'd8, 4'd9: prec = 3'd2;
      4'd4, 4'd5:             prec = 3'd1;
      default:                prec = 3'd0;
    endcase
  endfunction

  state_t state, state_n;
  mode_t  mode, mode_n;

  logic [W-1:0]  opnd   [DEPTH];
  logic [3:0]    op_stk [DEPTH];
  logic [CW-1:0] opnd_cnt, op_cnt;
  logic          expect_val, expect_n;
  logic [3:0]    pend, pend_n;
  logic [2:0]    err, err_new;

  logic          tok_fire;
  logic          push_opnd, push_op, pop_op, do_reduce, clear_all;
  logic [3:0]    push_op_val;
  logic          opnd_full, op_full, top_is_op;
  logic [3:0]    op_top;
  logic [AW-1:0] a_idx, b_idx;
  logic signed [W-1:0] alu_a, alu_b;
  logic [W-1:0]  alu_res;
  logic          div_zero;

  assign tok_fire  = tok_valid && tok_ready;
  assign opnd_full = (opnd_cnt == CW'(DEPTH));
  assign op_full   = (op_cnt == CW'(DEPTH));
  assign op_top    = op_stk[AW'(op_cnt - CW'(1))];
  assign top_is_op = (op_cnt != '0) && (op_top != OP_LPAREN);
  assign b_idx     = AW'(opnd_cnt - CW'(1));
  assign a_idx     = AW'(opnd_cnt - CW'(2));
  assign alu_a     = opnd[a_idx];
  assign alu_b     = opnd[b_idx];

  // Shared ALU: applies the operator on top of the op stack to the two
  // topmost operands (a below, b on top).
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case statements can leave it unassigned and infer a latch.
    alu_res  = '0;
    div_zero = 1'b0;
    case (op_top)
      4'd0: alu_res = alu_a + alu_b;
      4'd1: alu_res = alu_a - alu_b;
      4'd2: alu_res = alu_a * alu_b;
      4'd3: begin
        if (alu_b == '0)                         div_zero = 1'b1;
        else if (alu_a == S_MIN && alu_b == -1)  alu_res  = S_MIN;
        else                                     alu_res  = alu_a / alu_b;
      end
      4'd4: alu_res = W'(alu_a == alu_b);
      4'd5: alu_res = W'(alu_a != alu_b);
      4'd6: alu_res = W'(alu_a <  alu_b);
      4'd7: alu_res = W'(alu_a <= alu_b);
      4'd8: alu_res = W'(alu_a >  alu_b);
      4'd9: alu_res = W'(alu_a >= alu_b);
      default: alu_res = '0;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignment so every flop samples
    // pre-edge values regardless of process ordering.
    if (rst) state <= S_ACCEPT;
    else     state <= state_n;
  end

  // Next-state logic and stack actions for the current cycle.
  always_comb begin
    state_n     = state;
    mode_n      = mode;
    expect_n    = expect_val;
    pend_n      = pend;
    push_opnd   = 1'b0;
    push_op     = 1'b0;
    push_op_val = OP_LPAREN;
    pop_op      = 1'b0;
    do_reduce   = 1'b0;
    err_new     = 3'b000;
    clear_all   = 1'b0;
    case (state)
      S_ACCEPT: if (tok_fire) begin
        case (tok_kind)
          K_NUM:
            if (!expect_val)    err_new = ERR_SYN;
            else if (opnd_full) err_new = ERR_OVF;
            else begin
              push_opnd = 1'b1;
              expect_n  = 1'b0;
            end
          K_LPAREN:
            if (!expect_val)  err_new = ERR_SYN;
            else if (op_full) err_new = ERR_OVF;
            else begin
              push_op     = 1'b1;
              push_op_val = OP_LPAREN;
            end
          K_OP:
            if (expect_val || tok_op > OP_MAX) err_new = ERR_SYN;
            else begin
              pend_n = tok_op;
              if (top_is_op && prec(op_top) >= prec(tok_op)) begin
                mode_n  = M_OP;
                state_n = S_REDUCE;
              end else if (op_full) begin
                err_new = ERR_OVF;
              end else begin
                push_op     = 1'b1;
                push_op_val = tok_op;
                expect_n    = 1'b1;
              end
            end
          K_RPAREN:
            if (expect_val) err_new = ERR_SYN;
            else begin
              mode_n  = M_RPAREN;
              state_n = S_REDUCE;
            end
          K_END:
            if (expect_val)          err_new = ERR_SYN;
            else if (op_cnt == '0)   state_n = S_DONE;
            else begin
              mode_n  = M_END;
              state_n = S_REDUCE;
            end
          default: err_new = ERR_SYN;
        endcase
        // An error on END itself has nothing left to drain.
        if (err_new != 3'b000) state_n = (tok_kind == K_END) ? S_DONE : S_DRAIN;
      end
      S_REDUCE: begin
        case (mode)
          M_OP:
            if (top_is_op && prec(op_top) >= prec(pend)) begin
              if (div_zero) begin
                err_new = ERR_DIV;
                state_n = S_DRAIN;
              end else begin
                do_reduce = 1'b1;
              end
            end else if (op_full) begin
              err_new = ERR_OVF;
              state_n = S_DRAIN;
            end else begin
              push_op     = 1'b1;
              push_op_val = pend;
              expect_n    = 1'b1;
              state_n     = S_ACCEPT;
            end
          M_RPAREN:
            if (op_cnt == '0) begin
              err_new = ERR_SYN;
              state_n = S_DRAIN;
            end else if (op_top == OP_LPAREN) begin
              pop_op  = 1'b1;
              state_n = S_ACCEPT;
            end else if (div_zero) begin
              err_new = ERR_DIV;
              state_n = S_DRAIN;
            end else begin
              do_reduce = 1'b1;
            end
          default: begin
            // END already consumed: errors go straight to the result.
            if (op_top == OP_LPAREN) begin
              err_new = ERR_SYN;
              state_n = S_DONE;
            end else if (div_zero) begin
              err_new = ERR_DIV;
              state_n = S_DONE;
            end else begin
              do_reduce = 1'b1;
              if (op_cnt == CW'(1)) state_n = S_DONE;
            end
          end
        endcase
      end
      S_DRAIN:
        if (tok_fire && tok_kind == K_END) state_n = S_DONE;
      S_DONE:
        if (res_ready) begin
          clear_all = 1'b1;
          expect_n  = 1'b1;
          state_n   = S_ACCEPT;
        end
      default: state_n = S_ACCEPT;
    endcase
  end

  // Stack pointers, parse context and sticky error code.
  always_ff @(posedge clk) begin
    if (rst) begin
      opnd_cnt   <= '0;
      op_cnt     <= '0;
      expect_val <= 1'b1;
      pend       <= '0;
      mode       <= M_OP;
      err        <= 3'b000;
    end else if (clear_all) begin
      opnd_cnt   <= '0;
      op_cnt     <= '0;
      expect_val <= 1'b1;
      err        <= 3'b000;
    end else begin
      expect_val <= expect_n;
      pend       <= pend_n;
      mode       <= mode_n;
      if (err == 3'b000) err <= err_new;
      if (push_opnd)      opnd_cnt <= opnd_cnt + CW'(1);
      else if (do_reduce) opnd_cnt <= opnd_cnt - CW'(1);
      if (push_op)                  op_cnt <= op_cnt + CW'(1);
      else if (pop_op || do_reduce) op_cnt <= op_cnt - CW'(1);
    end
  end

  // Stack storage writes.
  always_ff @(posedge clk) begin
    // NOTE: stack storage is deliberately not reset; the counters define which
    // entries are live, so stale contents are never observed.
    if (push_opnd)      opnd[AW'(opnd_cnt)] <= tok_val;
    else if (do_reduce) opnd[a_idx]         <= alu_res;
    if (push_op)        op_stk[AW'(op_cnt)] <= push_op_val;
  end

  // Handshake and result outputs, forced idle while reset is asserted.
  always_comb begin
    tok_ready = !rst && (state == S_ACCEPT || state == S_DRAIN);
    res_valid = !rst && (state == S_DONE);
    res_err   = res_valid ? err : 3'b000;
    res_data  = (res_valid && err == 3'b000) ? opnd[0] : '0;
  end

endmodule

// File: tb/tb_expr_eval_sequencer.sv
// Testbench for expr_eval_sequencer: a table of token streams with expected
// results feeds a scoreboard; hand-written sequences cover reduce latency,
// result back-pressure and mid-expression reset.
module tb_expr_eval_sequencer;

  localparam int W     = 32;
  localparam int DEPTH = 8;

  localparam logic [2:0] K_NUM    = 3'd0;
  localparam logic [2:0] K_OP     = 3'd1;
  localparam logic [2:0] K_LPAREN = 3'd2;
  localparam logic [2:0] K_RPAREN = 3'd3;
  localparam logic [2:0] K_END    = 3'd4;

  localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, MUL = 4'd2, DIV = 4'd3;
  localparam logic [3:0] EQ = 4'd4, NE = 4'd5, LT = 4'd6, LE = 4'd7, GT = 4'd8, GE = 4'd9;

  logic         clk = 1'b0;
  logic         rst;
  logic         tok_valid;
  logic         tok_ready;
  logic [2:0]   tok_kind;
  logic [3:0]   tok_op;
  logic [W-1:0] tok_val;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res_data;
  logic [2:0]   res_err;

  always #5 clk = ~clk;

  expr_eval_sequencer #(.W(W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .tok_valid (tok_valid),
    .tok_ready (tok_ready),
    .tok_kind  (tok_kind),
    .tok_op    (tok_op),
    .tok_val   (tok_val),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_err   (res_err)
  );

  typedef struct packed {
    logic [2:0]   kind;
    logic [3:0]   op;
    logic [W-1:0] val;
  } tok_t;

  typedef struct {
    int           start;
    int           n;
    logic [W-1:0] exp_data;
    logic [2:0]   exp_err;
  } vec_t;

  typedef struct {
    logic [W-1:0] data;
    logic [2:0]   err;
  } exp_t;

  tok_t pool[$];
  vec_t vecs[32];
  int   nv = 0;
  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_res    = 0;

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endtask

  function automatic tok_t mk(input logic [2:0] k, input logic [3:0] o, input logic [W-1:0] v);
    tok_t t;
    t.kind = k;
    t.op   = o;
    t.val  = v;
    return t;
  endfunction

  task automatic vnew(input logic [W-1:0] d, input logic [2:0] e);
    vecs[nv].start    = pool.size();
    vecs[nv].n        = 0;
    vecs[nv].exp_data = d;
    vecs[nv].exp_err  = e;
    nv++;
  endtask

  task automatic tk(input logic [2:0] k, input logic [3:0] o, input logic [W-1:0] v);
    pool.push_back(mk(k, o, v));
    vecs[nv-1].n++;
  endtask

  task automatic num(input logic [W-1:0] v); tk(K_NUM, 4'd0, v);     endtask
  task automatic opr(input logic [3:0] o);   tk(K_OP, o, '0);         endtask
  task automatic lp();                       tk(K_LPAREN, 4'd0, '0);  endtask
  task automatic rp();                       tk(K_RPAREN, 4'd0, '0);  endtask
  task automatic en();                       tk(K_END, 4'd0, '0);     endtask

  task automatic expect_result(input logic [W-1:0] d, input logic [2:0] e);
    exp_t x;
    x.data = d;
    x.err  = e;
    sb_q.push_back(x);
  endtask

  // Drive one token and wait (bounded) for it to be accepted.
  task automatic send(input tok_t t);
    int n;
    n = 0;
    tok_valid = 1'b1;
    tok_kind  = t.kind;
    tok_op    = t.op;
    tok_val   = t.val;
    forever begin
      @(negedge clk);
      if (tok_ready) break;
      n++;
      if (n > 200) begin
        n_checks++;
        n_fail++;
        $display("FAIL tok_handshake: tok_ready stayed 0 for %0d cycles, expected 1", n);
        break;
      end
    end
    @(posedge clk);
    #1;
    tok_valid = 1'b0;
  endtask

  // Result monitor: compare each accepted result against the scoreboard.
  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_result: got data 0x%08h err %b, expected no result", res_data, res_err);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check($sformatf("res_data[%0d]", n_res), res_data, e.data);
        check($sformatf("res_err[%0d]", n_res), 32'(res_err), 32'(e.err));
      end
      n_res++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    logic [W-1:0] held;

    rst       = 1'b1;
    tok_valid = 1'b0;
    tok_kind  = '0;
    tok_op    = '0;
    tok_val   = '0;
    res_ready = 1'b1;

    // ---- vector table -----------------------------------------------------
    vnew(32'd20, 3'b000);         lp(); num(2); opr(ADD); num(3); rp(); opr(MUL); num(4); en();
    vnew(32'd3, 3'b000);          num(10); opr(SUB); num(4); opr(SUB); num(3); en();
    vnew(32'hFFFF_FFFD, 3'b000);  num(7); opr(DIV); num(32'hFFFF_FFFE); en();
    vnew(32'd1, 3'b000);          num(3); opr(LT); num(5); opr(EQ); num(1); en();
    vnew(32'h8000_0000, 3'b000);  num(32'h7FFF_FFFF); opr(ADD); num(1); en();
    vnew(32'd0, 3'b010);          num(5); opr(DIV); lp(); num(2); opr(SUB); num(2); rp(); en();
    vnew(32'd1, 3'b000);          num(1); en();
    vnew(32'd0, 3'b001);
    for (int i = 0; i < 9; i++) lp();
    num(1);
    for (int i = 0; i < 9; i++) rp();
    en();
    vnew(32'd1, 3'b000);
    for (int i = 0; i < DEPTH; i++) lp();
    num(1);
    for (int i = 0; i < DEPTH; i++) rp();
    en();
    vnew(32'd0, 3'b100);          num(2); opr(ADD); opr(MUL); num(3); en();
    vnew(32'h8000_0000, 3'b000);  num(32'h8000_0000); opr(DIV); num(32'hFFFF_FFFF); en();
    vnew(32'hFFFF_FFFD, 3'b000);  num(32'hFFFF_FFF9); opr(DIV); num(2); en();
    vnew(32'd0, 3'b000);          num(32'h0001_0000); opr(MUL); num(32'h0001_0000); en();
    vnew(32'd1, 3'b000);          num(32'hFFFF_FFFF); opr(LT); num(1); en();
    vnew(32'd26, 3'b000);         num(2); opr(MUL); num(3); opr(ADD); num(4); opr(MUL); num(5); en();
    vnew(32'd0, 3'b000);          num(6); opr(NE); num(6); en();
    vnew(32'd1, 3'b000);          num(7); opr(GE); num(7); en();
    vnew(32'd1, 3'b000);          num(9); opr(GT); num(3); opr(SUB); num(8); en();
    vnew(32'd1, 3'b000);          num(8); opr(LE); num(2); opr(MUL); num(4); en();
    vnew(32'd3, 3'b000);          num(20); opr(DIV); num(3); opr(DIV); num(2); en();
    vnew(32'd0, 3'b100);          num(1); rp(); en();
    vnew(32'd0, 3'b100);          lp(); num(1); en();
    vnew(32'd0, 3'b100);          num(1); opr(4'd12); num(2); en();
    vnew(32'd0, 3'b100);          num(1); tk(3'd6, 4'd0, '0); en();
    vnew(32'd0, 3'b100);          en();

    // ---- reset state ------------------------------------------------------
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_tok_ready", 32'(tok_ready), 32'd0);
    check("reset_res_valid", 32'(res_valid), 32'd0);
    check("reset_res_data", res_data, 32'd0);
    check("reset_res_err", 32'(res_err), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("tok_ready_after_reset", 32'(tok_ready), 32'd1);
    @(posedge clk);
    #1;

    // ---- table-driven expressions ----------------------------------------
    for (int i = 0; i < nv; i++) begin
      expect_result(vecs[i].exp_data, vecs[i].exp_err);
      for (int j = 0; j < vecs[i].n; j++) send(pool[vecs[i].start + j]);
    end

    // ---- reduce latency after END: 2 + 3 * 4 ------------------------------
    expect_result(32'd14, 3'b000);
    send(mk(K_NUM, 4'd0, 32'd2));
    send(mk(K_OP, ADD, '0));
    send(mk(K_NUM, 4'd0, 32'd3));
    send(mk(K_OP, MUL, '0));
    send(mk(K_NUM, 4'd0, 32'd4));
    send(mk(K_END, 4'd0, '0));
    cnt = 0;
    forever begin
      @(negedge clk);
      if (res_valid || cnt > 50) break;
      cnt++;
    end
    check("reduce_cycles_after_end", 32'(cnt), 32'd2);
    @(posedge clk);
    #1;

    // ---- back-pressure: hold res_ready low for 10 cycles ------------------
    res_ready = 1'b0;
    expect_result(32'd5, 3'b000);
    send(mk(K_NUM, 4'd0, 32'd2));
    send(mk(K_OP, ADD, '0));
    send(mk(K_NUM, 4'd0, 32'd3));
    send(mk(K_END, 4'd0, '0));
    cnt = 0;
    forever begin
      @(negedge clk);
      if (res_valid || cnt > 50) break;
      cnt++;
    end
    check("hold_res_valid_seen", 32'(res_valid), 32'd1);
    held = 32'd5;
    tok_valid = 1'b1;
    tok_kind  = K_NUM;
    tok_val   = 32'd99;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("hold_res_valid[%0d]", i), 32'(res_valid), 32'd1);
      check($sformatf("hold_res_data[%0d]", i), res_data, held);
      check($sformatf("hold_tok_ready[%0d]", i), 32'(tok_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    tok_valid = 1'b0;
    res_ready = 1'b1;
    @(posedge clk);
    #1;

    // ---- reset in the middle of an expression ----------------------------
    send(mk(K_NUM, 4'd0, 32'd7));
    send(mk(K_OP, ADD, '0));
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("midrst_tok_ready", 32'(tok_ready), 32'd0);
    check("midrst_res_valid", 32'(res_valid), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    expect_result(32'd4, 3'b000);
    send(mk(K_NUM, 4'd0, 32'd4));
    send(mk(K_END, 4'd0, '0));

    // ---- let outstanding results drain -----------------------------------
    cnt = 0;
    while (sb_q.size() != 0 && cnt < 1000) begin
      @(negedge clk);
      cnt++;
    end
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
